z80_bus_responder: RTL



---
 rtl/z80_bus_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/z80_bus_responder.sv
// Pin-level Z80 bus slave: byte RAM window, one I/O register, programmable wait states.
// Optional macro RESP_INTA_EN: answer interrupt-acknowledge cycles with INT_VECTOR.
module z80_bus_responder #(
    parameter int          AW         = 10,
    parameter logic [15:0] MEM_BASE   = 16'h0000,
    parameter logic [7:0]  IO_PORT    = 8'h10,
    parameter int          WAIT_MEM   = 0,
    parameter int          WAIT_IO    = 1,
    parameter logic [7:0]  INT_VECTOR = 8'hFF
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [15:0] address,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nM1,
    input  logic        nRFSH,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic        nWAIT,
    output logic [7:0]  io_reg
);

    localparam logic [3:0] L_WAIT_MEM = 4'(WAIT_MEM);
    localparam logic [3:0] L_WAIT_IO  = 4'(WAIT_IO);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_DONE} state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_is_io;
    logic           r_is_rd;
    logic           r_is_inta;
    logic [AW-1:0]  r_idx;
    logic [7:0]     r_d_out;
    logic           r_d_oe;
    logic           r_nwait;
    logic [7:0]     r_io_reg;
    logic [7:0]     r_ram [0:(2**AW)-1];

    state_t         w_state_next;
    logic [3:0]     w_cnt_next;
    logic           w_d_oe_next;
    logic           w_nwait_next;
    logic           w_latch;
    logic           w_ram_we;
    logic           w_io_we;

    logic           w_rdwr;
    logic           w_win_hit;
    logic           w_mem_req;
    logic           w_io_req;
    logic           w_inta_req;
    logic           w_accept;
    logic           w_acc_io;
    logic           w_acc_inta;
    logic           w_acc_rd;
    logic [3:0]     w_acc_wait;
    logic [7:0]     w_rd_data;
    logic           w_strobe_high;
    logic           w_bus_idle;

    assign w_rdwr    = !nRD || !nWR;
    assign w_win_hit = (address[15:AW] == MEM_BASE[15:AW]);
    assign w_mem_req = !nMREQ && nRFSH && w_rdwr && w_win_hit;
    assign w_io_req  = !nIORQ && nM1 && w_rdwr && (address[7:0] == IO_PORT);
`ifdef RESP_INTA_EN
    assign w_inta_req = !nIORQ && !nM1;
`else
    assign w_inta_req = 1'b0;
`endif

    // Memory wins if both request strobes are (illegally) low together.
    assign w_accept   = w_mem_req || w_io_req || w_inta_req;
    assign w_acc_inta = !w_mem_req && w_inta_req;
    assign w_acc_io   = !w_mem_req && (w_io_req || w_inta_req);
    assign w_acc_rd   = w_acc_inta || !nRD;
    assign w_acc_wait = w_acc_io ? L_WAIT_IO : L_WAIT_MEM;
    assign w_rd_data  = w_acc_inta ? INT_VECTOR :
                        w_acc_io   ? r_io_reg   : r_ram[address[AW-1:0]];

    // INTA cycles carry no nRD/nWR, so only nIORQ ends them.
    assign w_strobe_high = r_is_io ? nIORQ : nMREQ;
    assign w_bus_idle    = w_strobe_high && (r_is_inta || (nRD && nWR));

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_d_oe_next  = r_d_oe;
        w_nwait_next = r_nwait;
        w_latch      = 1'b0;
        w_ram_we     = 1'b0;
        w_io_we      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_d_oe_next  = 1'b0;
                w_nwait_next = 1'b1;
                if (w_accept) begin
                    w_latch = 1'b1;
                    if (w_acc_wait != 4'd0) begin
                        w_cnt_next   = w_acc_wait;
                        w_nwait_next = 1'b0;
                        w_state_next = S_WAIT;
                    end else begin
                        w_state_next = S_ACTIVE;
                    end
                end
            end
            S_WAIT: begin
                if (w_strobe_high) begin
                    w_cnt_next   = 4'd0;
                    w_nwait_next = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_cnt <= 4'd1) begin
                    w_cnt_next   = 4'd0;
                    w_nwait_next = 1'b1;
                    w_state_next = S_ACTIVE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_ACTIVE: begin
                if (w_strobe_high) begin
                    w_d_oe_next  = 1'b0;
                    w_state_next = S_IDLE;
                end else begin
                    if (r_is_rd)      w_d_oe_next = 1'b1;
                    else if (r_is_io) w_io_we     = 1'b1;
                    else              w_ram_we    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_bus_idle) begin
                    w_d_oe_next  = 1'b0;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_is_io   <= 1'b0;
            r_is_rd   <= 1'b0;
            r_is_inta <= 1'b0;
            r_idx     <= '0;
            r_d_out   <= 8'h00;
            r_d_oe    <= 1'b0;
            r_nwait   <= 1'b1;
            r_io_reg  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_d_oe  <= w_d_oe_next;
            r_nwait <= w_nwait_next;
            if (w_latch) begin
                r_is_io   <= w_acc_io;
                r_is_rd   <= w_acc_rd;
                r_is_inta <= w_acc_inta;
                r_idx     <= address[AW-1:0];
                r_d_out   <= w_rd_data;
            end
            if (w_io_we) r_io_reg <= d_in;
        end
    end

    // RAM contents survive reset, so the array lives outside the reset block.
    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[r_idx] <= d_in;
    end

    assign d_out  = r_d_out;
    assign d_oe   = r_d_oe;
    assign nWAIT  = r_nwait;
    assign io_reg = r_io_reg;

endmodule
